phy_rx_sp: RTL and testbench



---
 rtl/phy_rx_sp.sv | 158 +++++++++++++++
 tb/tb_phy_rx_sp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_sp.sv
// Serial-to-parallel receiver: comma (BC) hunt, BC_LOCK-comma lock, lane-tagged byte strobes.
// Optional per-lane output registers when PHY_RX_LANE_DEMUX_EN is defined.
module phy_rx_sp #(
  parameter logic [7:0]  BC      = 8'hBC,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_sp,
  output logic       valid_sp,
  output logic [1:0] lane_sp,
  output logic       active
`ifdef PHY_RX_LANE_DEMUX_EN
  ,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       validout0,
  output logic       validout1,
  output logic       validout2,
  output logic       validout3
`endif
);

  typedef enum logic [1:0] {HUNT, ALIGN, ACTIVE} state_e;

  localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK);

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [1:0] lane_cnt_q, lane_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [1:0] lane_q, lane_d;

  logic [7:0] nsr;
  logic       byte_done;
  logic       is_bc;
  logic [3:0] bc_cnt_inc;

`ifdef PHY_RX_LANE_DEMUX_EN
  logic [7:0] out_q [4];
  logic [7:0] out_d [4];
  logic [3:0] vout_q, vout_d;
`endif

  assign nsr        = {sr_q[6:0], data_in};
  assign byte_done  = (bit_cnt_q == 3'd7);
  assign is_bc      = (nsr == BC);
  assign bc_cnt_inc = bc_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    sr_d       = nsr;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    bc_cnt_d   = bc_cnt_q;
    lane_cnt_d = lane_cnt_q;
    data_d     = data_q;
    lane_d     = lane_q;
    valid_d    = 1'b0;
`ifdef PHY_RX_LANE_DEMUX_EN
    out_d      = out_q;
    vout_d     = vout_q;
`endif
    case (state_q)
      HUNT: begin
        if (is_bc) begin
          bit_cnt_d = '0;
          bc_cnt_d  = 4'd1;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        if (byte_done) begin
          if (is_bc) begin
            if (bc_cnt_inc == LOCK_CNT) begin
              state_d    = ACTIVE;
              lane_cnt_d = '0;
              bc_cnt_d   = '0;
            end else begin
              bc_cnt_d = bc_cnt_inc;
            end
          end else begin
            // Misaligned byte: back to hunting; this edge is not rechecked as a hunt match.
            state_d  = HUNT;
            bc_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (byte_done) begin
          lane_cnt_d = lane_cnt_q + 2'd1;
          if (!is_bc) begin
            data_d  = nsr;
            lane_d  = lane_cnt_q;
            valid_d = 1'b1;
          end
`ifdef PHY_RX_LANE_DEMUX_EN
          vout_d[lane_cnt_q] = !is_bc;
          if (!is_bc) out_d[lane_cnt_q] = nsr;
`endif
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      bc_cnt_q   <= '0;
      lane_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      lane_q     <= '0;
`ifdef PHY_RX_LANE_DEMUX_EN
      for (int unsigned i = 0; i < 4; i++) out_q[i] <= '0;
      vout_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      lane_q     <= lane_d;
`ifdef PHY_RX_LANE_DEMUX_EN
      out_q      <= out_d;
      vout_q     <= vout_d;
`endif
    end
  end

  assign data_sp  = data_q;
  assign valid_sp = valid_q;
  assign lane_sp  = lane_q;
  assign active   = (state_q == ACTIVE);

`ifdef PHY_RX_LANE_DEMUX_EN
  assign out0      = out_q[0];
  assign out1      = out_q[1];
  assign out2      = out_q[2];
  assign out3      = out_q[3];
  assign validout0 = vout_q[0];
  assign validout1 = vout_q[1];
  assign validout2 = vout_q[2];
  assign validout3 = vout_q[3];
`endif

endmodule

// File: tb/tb_phy_rx_sp.sv
// Randomized bench for phy_rx_sp: per-cycle comparison against a byte-phase reference model
// plus directed lock / abort / empty-lane / wrap scenarios.
module tb_phy_rx_sp;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_sp;
  logic       valid_sp;
  logic [1:0] lane_sp;
  logic       active;
`ifdef PHY_RX_LANE_DEMUX_EN
  logic [7:0] out0, out1, out2, out3;
  logic       validout0, validout1, validout2, validout3;
`endif

  phy_rx_sp #(.BC(8'hBC), .BC_LOCK(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_sp  (data_sp),
    .valid_sp (valid_sp),
    .lane_sp  (lane_sp),
    .active   (active)
`ifdef PHY_RX_LANE_DEMUX_EN
    ,
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .validout0 (validout0),
    .validout1 (validout1),
    .validout2 (validout2),
    .validout3 (validout3)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: alignment tracked as an anchor edge index; bytes complete every 8th edge after it.
  int         m_mode;     // 0 hunt, 1 counting commas, 2 active
  logic [7:0] m_hist;
  int         m_n, m_anchor, m_commas, m_slot;
  logic [7:0] m_data;
  logic       m_valid;
  logic [1:0] m_lane;
  logic [7:0] m_out [4];
  logic       m_vout [4];

  task automatic model_reset();
    m_mode = 0; m_hist = '0; m_n = 0; m_anchor = 0; m_commas = 0; m_slot = 0;
    m_data = '0; m_valid = 1'b0; m_lane = '0;
    for (int i = 0; i < 4; i++) begin m_out[i] = '0; m_vout[i] = 1'b0; end
  endtask

  task automatic model_step(input logic b);
    logic done;
    int   ln;
    m_hist  = {m_hist[6:0], b};
    m_n++;
    m_valid = 1'b0;
    done    = (m_n > m_anchor) && (((m_n - m_anchor) % 8) == 0);
    if (m_mode == 0) begin
      if (m_hist == BC) begin m_mode = 1; m_anchor = m_n; m_commas = 1; end
    end else if (m_mode == 1) begin
      if (done) begin
        if (m_hist == BC) begin
          m_commas++;
          if (m_commas == 4) begin m_mode = 2; m_slot = 0; end
        end else m_mode = 0;
      end
    end else if (done) begin
      ln = m_slot % 4;
      if (m_hist != BC) begin
        m_data = m_hist; m_lane = 2'(ln); m_valid = 1'b1;
        m_out[ln] = m_hist; m_vout[ln] = 1'b1;
      end else m_vout[ln] = 1'b0;
      m_slot++;
    end
  endtask

  int p_data[$];
  int p_lane[$];
  int p_cyc[$];

  task automatic clear_pulses();
    p_data.delete(); p_lane.delete(); p_cyc.delete();
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    cyc++;
    if (!reset) model_reset(); else model_step(b);
    @(negedge clk_32f);
    chk("valid_sp", 32'(valid_sp), 32'(m_valid));
    chk("active",   32'(active),   32'(m_mode == 2));
    chk("data_sp",  32'(data_sp),  32'(m_data));
    chk("lane_sp",  32'(lane_sp),  32'(m_lane));
`ifdef PHY_RX_LANE_DEMUX_EN
    chk("out0", 32'(out0), 32'(m_out[0]));  chk("validout0", 32'(validout0), 32'(m_vout[0]));
    chk("out1", 32'(out1), 32'(m_out[1]));  chk("validout1", 32'(validout1), 32'(m_vout[1]));
    chk("out2", 32'(out2), 32'(m_out[2]));  chk("validout2", 32'(validout2), 32'(m_vout[2]));
    chk("out3", 32'(out3), 32'(m_out[3]));  chk("validout3", 32'(validout3), 32'(m_vout[3]));
`endif
    if (valid_sp) begin
      p_data.push_back(int'(data_sp)); p_lane.push_back(int'(lane_sp)); p_cyc.push_back(cyc);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    model_reset();
    send_rand_bits(n);
    chk("rst_data",   32'(data_sp),  32'h0);
    chk("rst_valid",  32'(valid_sp), 32'h0);
    chk("rst_lane",   32'(lane_sp),  32'h0);
    chk("rst_active", 32'(active),   32'h0);
    reset = 1'b1;
  endtask

  task automatic lock_up();
    apply_reset(5);
    send_rand_bits(3);
    repeat (4) send_byte(BC);
    clear_pulses();
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    model_reset();

    // Reset held mid-stream, released mid-byte: no strobes may follow from junk.
    apply_reset(13);
    clear_pulses();
    send_rand_bits(5);
    chk("post_rst_pulses", 32'(p_data.size()), 32'd0);

    // Lock
    apply_reset(11);
    send_rand_bits(3);
    repeat (3) send_byte(BC);
    chk("pre_lock_active", 32'(active), 32'd0);
    send_byte(BC);
    chk("lock_active", 32'(active), 32'd1);
    clear_pulses();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)));
    chk("lock_npulse", 32'(p_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < p_data.size(); i++) begin
      chk("lock_data", 32'(p_data[i]), 32'(8'h11 * (i + 1)));
      chk("lock_lane", 32'(p_lane[i]), 32'(i));
      if (i > 0) chk("lock_spacing", 32'(p_cyc[i] - p_cyc[i-1]), 32'd8);
    end
`ifdef PHY_RX_LANE_DEMUX_EN
    chk("dmx_out0", 32'(out0), 32'h11); chk("dmx_out1", 32'(out1), 32'h22);
    chk("dmx_out2", 32'(out2), 32'h33); chk("dmx_out3", 32'(out3), 32'h44);
    chk("dmx_vall", 32'({validout0, validout1, validout2, validout3}), 32'hF);
    send_byte(8'h55);
    send_byte(BC);
    chk("dmx_empty_v1", 32'(validout1), 32'd0);
    chk("dmx_hold_o1",  32'(out1), 32'h22);
    send_byte(8'h66);
    send_byte(8'h77);
`endif

    // Lock abort and re-lock
    apply_reset(4);
    send_rand_bits(3);
    send_byte(BC); send_byte(BC); send_byte(8'h5A);
    chk("abort_active", 32'(active), 32'd0);
    repeat (4) send_byte(BC);
    chk("relock_active", 32'(active), 32'd1);
    clear_pulses();
    send_byte(8'h77);
    chk("relock_npulse", 32'(p_data.size()), 32'd1);
    if (p_data.size() > 0) begin
      chk("relock_data", 32'(p_data[0]), 32'h77);
      chk("relock_lane", 32'(p_lane[0]), 32'd0);
    end

    // Empty lane slot
    lock_up();
    send_byte(8'hA1);
    send_byte(BC);
    chk("empty_hold", 32'(data_sp), 32'hA1);
    send_byte(8'hC3);
    send_byte(8'hD4);
    chk("empty_npulse", 32'(p_data.size()), 32'd3);
    if (p_data.size() == 3) begin
      chk("empty_d0", 32'(p_data[0]), 32'hA1); chk("empty_l0", 32'(p_lane[0]), 32'd0);
      chk("empty_d1", 32'(p_data[1]), 32'hC3); chk("empty_l1", 32'(p_lane[1]), 32'd2);
      chk("empty_d2", 32'(p_data[2]), 32'hD4); chk("empty_l2", 32'(p_lane[2]), 32'd3);
    end

    // Lane wrap and all-zero persistence
    lock_up();
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    repeat (32) send_bit(1'b0);
    chk("wrap_npulse", 32'(p_data.size()), 32'd16);
    for (int i = 0; i < 16 && i < p_data.size(); i++) begin
      chk("wrap_data", 32'(p_data[i]), (i < 12) ? 32'(i) : 32'd0);
      chk("wrap_lane", 32'(p_lane[i]), 32'(i % 4));
    end
    chk("wrap_active", 32'(active), 32'd1);

    // Randomized rounds: junk, optional aborted lock, lock, random bytes, optional mid-byte reset.
    for (int r = 0; r < 8; r++) begin
      apply_reset(int'($urandom_range(1, 10)));
      send_rand_bits(int'($urandom_range(0, 20)));
      if ($urandom_range(0, 1) == 1) begin
        send_byte(BC);
        send_byte(8'($urandom_range(0, 255)));
      end
      repeat (4) send_byte(BC);
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 3) == 0) send_byte(BC);
        else send_byte(8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 1) == 1) begin
        send_rand_bits(int'($urandom_range(1, 7)));
        apply_reset(int'($urandom_range(1, 5)));
        send_rand_bits(int'($urandom_range(1, 12)));
      end
    end
    apply_reset(3);
    send_rand_bits(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
